// File: rtl/msft_dbg_apb_master.sv
// -----------------------------------------------------------------------------
// msft_dbg_apb_master
//
// Debug-side APB requester. Takes single-beat read/write commands from the
// debug transport on a valid/ready request channel, runs each one as a single
// APB SETUP/ACCESS transfer on the debug APB port, and returns read data and
// error status on a valid/ready response channel. Only one transfer is ever
// outstanding, and the request and response phases never overlap.
//
// Optional feature (compile-time macro MSFT_DBG_APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that is still waiting after TIMEOUT_CYCLES
//   cycles is aborted and answered with rsp_err_o=1, rsp_timeout_o=1 and
//   rsp_rdata_o=0. When undefined, ACCESS waits for pready_dbg_i forever and
//   rsp_timeout_o is tied low.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    command handshake
//   req_addr_i, req_wdata_i,
//   req_write_i, req_strb_i      command fields (sampled on acceptance)
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                response fields (stable while rsp_valid_o)
//   busy_o                       high whenever a command is in flight
//   psel_dbg_o .. pstrb_dbg_o    APB requester outputs
//   prdata_dbg_i, pready_dbg_i,
//   psuberr_dbg_i                APB completer inputs
// -----------------------------------------------------------------------------
module msft_dbg_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // request channel
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic                        req_write_i,
  input  logic [APB_DATA_WIDTH/8-1:0] req_strb_i,
  // response channel
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        rsp_timeout_o,
  output logic                        busy_o,
  // debug APB port
  output logic                        psel_dbg_o,
  output logic                        penable_dbg_o,
  output logic                        pwrite_dbg_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_dbg_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_dbg_o,
  output logic [APB_DATA_WIDTH/8-1:0] pstrb_dbg_o,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_dbg_i,
  input  logic                        pready_dbg_i,
  input  logic                        psuberr_dbg_i
);

  localparam int STRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                      state_reg;
  logic                        req_ready_reg;
  logic                        busy_reg;
  logic                        psel_reg;
  logic                        penable_reg;
  logic                        pwrite_reg;
  logic [APB_ADDR_WIDTH-1:0]   paddr_reg;
  logic [APB_DATA_WIDTH-1:0]   pwdata_reg;
  logic [STRB_WIDTH-1:0]       pstrb_reg;
  logic                        rsp_valid_reg;
  logic [APB_DATA_WIDTH-1:0]   rsp_rdata_reg;
  logic                        rsp_err_reg;

`ifdef MSFT_DBG_APB_TIMEOUT_EN
  // Counter holds the number of ACCESS wait cycles already seen. The abort
  // fires in the ACCESS cycle whose wait would bring the count to
  // TIMEOUT_CYCLES, so exactly TIMEOUT_CYCLES ACCESS cycles are spent.
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [CNT_WIDTH-1:0] wait_cnt_reg;
  logic                 rsp_timeout_reg;

  assign rsp_timeout_o = rsp_timeout_reg;
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 1);
  assign rsp_timeout_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      req_ready_reg   <= 1'b1;
      busy_reg        <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pstrb_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
`ifdef MSFT_DBG_APB_TIMEOUT_EN
      wait_cnt_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            // Reads carry no data and no strobes onto the bus.
            paddr_reg     <= req_addr_i;
            pwrite_reg    <= req_write_i;
            pwdata_reg    <= req_write_i ? req_wdata_i : '0;
            pstrb_reg     <= req_write_i ? req_strb_i : '0;
            psel_reg      <= 1'b1;
            penable_reg   <= 1'b0;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable_reg  <= 1'b1;
          state_reg    <= ST_ACCESS;
`ifdef MSFT_DBG_APB_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end

        ST_ACCESS: begin
          // pready has priority over a timeout reached in the same cycle.
          if (pready_dbg_i) begin
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= pwrite_reg ? '0 : prdata_dbg_i;
            rsp_err_reg     <= psuberr_dbg_i;
`ifdef MSFT_DBG_APB_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
`endif
            state_reg       <= ST_RESP;
          end
`ifdef MSFT_DBG_APB_TIMEOUT_EN
          else if (wait_cnt_reg >= CNT_LAST) begin
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            state_reg       <= ST_RESP;
          end else if (wait_cnt_reg != CNT_MAX) begin
            wait_cnt_reg    <= wait_cnt_reg + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          // Request side stays closed through the handshake cycle itself.
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = req_ready_reg;
  assign busy_o        = busy_reg;
  assign psel_dbg_o    = psel_reg;
  assign penable_dbg_o = penable_reg;
  assign pwrite_dbg_o  = pwrite_reg;
  assign paddr_dbg_o   = paddr_reg;
  assign pwdata_dbg_o  = pwdata_reg;
  assign pstrb_dbg_o   = pstrb_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_rdata_o   = rsp_rdata_reg;
  assign rsp_err_o     = rsp_err_reg;

endmodule

// File: tb/tb_msft_dbg_apb_master.sv
// -----------------------------------------------------------------------------
// tb_msft_dbg_apb_master
//
// Directed and randomized transactions against msft_dbg_apb_master. Inputs are
// driven and outputs sampled on the falling clock edge. The expected response
// of every transaction is derived from its parameters alone: number of ACCESS
// cycles, read data, error and timeout follow directly from the command and
// the completer's wait/err/data choice.
// -----------------------------------------------------------------------------
module tb_msft_dbg_apb_master;

  localparam int TO = 8;
`ifdef MSFT_DBG_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_write_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic        psel_dbg_o;
  logic        penable_dbg_o;
  logic        pwrite_dbg_o;
  logic [31:0] paddr_dbg_o;
  logic [31:0] pwdata_dbg_o;
  logic [3:0]  pstrb_dbg_o;
  logic [31:0] prdata_dbg_i;
  logic        pready_dbg_i;
  logic        psuberr_dbg_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  msft_dbg_apb_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_write_i  (req_write_i),
    .req_strb_i   (req_strb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .busy_o       (busy_o),
    .psel_dbg_o   (psel_dbg_o),
    .penable_dbg_o(penable_dbg_o),
    .pwrite_dbg_o (pwrite_dbg_o),
    .paddr_dbg_o  (paddr_dbg_o),
    .pwdata_dbg_o (pwdata_dbg_o),
    .pstrb_dbg_o  (pstrb_dbg_o),
    .prdata_dbg_i (prdata_dbg_i),
    .pready_dbg_i (pready_dbg_i),
    .psuberr_dbg_i(psuberr_dbg_i)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_apb(input string ph, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    chk32({ph, "_paddr"},  paddr_dbg_o,  a);
    chk1 ({ph, "_pwrite"}, pwrite_dbg_o, w);
    chk32({ph, "_pwdata"}, pwdata_dbg_o, d);
    chk32({ph, "_pstrb"},  {28'h0, pstrb_dbg_o}, {28'h0, s});
  endtask

  // Scramble request inputs while the DUT must ignore them.
  task automatic garbage_req();
    req_valid_i = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_write_i = 1'($urandom);
    req_strb_i  = 4'($urandom);
  endtask

  // One complete transaction. Called at a falling edge with the DUT idle.
  // waits: ACCESS cycles with pready low before pready goes high.
  // hold:  cycles rsp_ready stays low once the response is valid.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr, input logic [3:0] strb, input int waits,
                         input logic serr, input logic [31:0] rdat, input int hold);
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        to;
    int          n_acc;
    e_wdata = wr ? wdata : 32'h0;
    e_strb  = wr ? strb : 4'h0;
    to      = TO_EN && (waits >= TO);
    n_acc   = to ? TO : waits + 1;
    e_rdata = (to || wr) ? 32'h0 : rdat;
    e_err   = to ? 1'b1 : serr;

    chk1("idle_req_ready", req_ready_o, 1'b1);
    chk1("idle_busy", busy_o, 1'b0);
    chk1("idle_psel", psel_dbg_o, 1'b0);
    chk1("idle_rsp_valid", rsp_valid_o, 1'b0);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_write_i = wr;
    req_strb_i  = strb;

    @(negedge clk_i);
    garbage_req();
    chk1("setup_psel", psel_dbg_o, 1'b1);
    chk1("setup_penable", penable_dbg_o, 1'b0);
    chk1("setup_req_ready", req_ready_o, 1'b0);
    chk1("setup_busy", busy_o, 1'b1);
    chk1("setup_rsp_valid", rsp_valid_o, 1'b0);
    chk_apb("setup", addr, wr, e_wdata, e_strb);

    for (int i = 0; i < n_acc; i++) begin
      @(negedge clk_i);
      garbage_req();
      chk1("access_psel", psel_dbg_o, 1'b1);
      chk1("access_penable", penable_dbg_o, 1'b1);
      chk1("access_req_ready", req_ready_o, 1'b0);
      chk1("access_rsp_valid", rsp_valid_o, 1'b0);
      chk_apb("access", addr, wr, e_wdata, e_strb);
      pready_dbg_i  = (i == waits);
      prdata_dbg_i  = (i == waits) ? rdat : $urandom;
      psuberr_dbg_i = (i == waits) ? serr : 1'($urandom);
    end

    @(negedge clk_i);
    pready_dbg_i  = 1'b0;
    prdata_dbg_i  = $urandom;
    psuberr_dbg_i = 1'($urandom);
    for (int h = 0; h <= hold; h++) begin
      chk1("rsp_valid", rsp_valid_o, 1'b1);
      chk32("rsp_rdata", rsp_rdata_o, e_rdata);
      chk1("rsp_err", rsp_err_o, e_err);
      chk1("rsp_timeout", rsp_timeout_o, to);
      chk1("rsp_psel", psel_dbg_o, 1'b0);
      chk1("rsp_penable", penable_dbg_o, 1'b0);
      chk1("rsp_req_ready", req_ready_o, 1'b0);
      chk1("rsp_busy", busy_o, 1'b1);
      garbage_req();
      rsp_ready_i = (h == hold);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk1("done_rsp_valid", rsp_valid_o, 1'b0);
    chk1("done_req_ready", req_ready_o, 1'b1);
    chk1("done_busy", busy_o, 1'b0);
    $display("txn addr=%h wr=%0d waits=%0d err=%0d to=%0d rdata=%h", addr, wr, waits, e_err, to, e_rdata);
  endtask

  initial begin
    rst_i         = 1'b1;
    req_valid_i   = 1'b0;
    req_addr_i    = '0;
    req_wdata_i   = '0;
    req_write_i   = 1'b0;
    req_strb_i    = '0;
    rsp_ready_i   = 1'b0;
    prdata_dbg_i  = '0;
    pready_dbg_i  = 1'b0;
    psuberr_dbg_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset state
    chk1("rst_req_ready", req_ready_o, 1'b1);
    chk1("rst_psel", psel_dbg_o, 1'b0);
    chk1("rst_penable", penable_dbg_o, 1'b0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_rsp_err", rsp_err_o, 1'b0);
    chk1("rst_rsp_timeout", rsp_timeout_o, 1'b0);
    chk32("rst_paddr", paddr_dbg_o, 32'h0);
    chk32("rst_rdata", rsp_rdata_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Zero-wait read
    run_txn(32'h1000_0004, 32'h0, 1'b0, 4'hF, 0, 1'b0, 32'hA5A5_1234, 0);
    // Write with three wait states, response held off five cycles
    run_txn(32'h2000_0010, 32'hCAFE_F00D, 1'b1, 4'h3, 3, 1'b0, 32'h1111_2222, 5);
    // Unmapped read returns a slave error
    run_txn(32'h3000_0000, 32'h0, 1'b0, 4'h0, 0, 1'b1, 32'h0BAD_0BAD, 1);
    // Completer never ready in time: timeout when enabled, else long wait
    run_txn(32'h4000_0008, 32'h0, 1'b0, 4'h0, 20, 1'b0, 32'h7777_8888, 0);
    // pready arrives in the 8th ACCESS cycle: always normal completion
    run_txn(32'h4000_000C, 32'h0, 1'b0, 4'h0, TO - 1, 1'b0, 32'h1357_9BDF, 0);
    run_txn(32'h4000_0010, 32'h5555_AAAA, 1'b1, 4'hC, TO - 1, 1'b1, 32'hFFFF_FFFF, 2);

    // Reset pulse during ACCESS discards the transfer
    req_valid_i = 1'b1;
    req_addr_i  = 32'h5000_0000;
    req_write_i = 1'b0;
    req_strb_i  = 4'hF;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk1("mid_access_penable", penable_dbg_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk1("mid_rst_psel", psel_dbg_o, 1'b0);
    chk1("mid_rst_penable", penable_dbg_o, 1'b0);
    chk1("mid_rst_busy", busy_o, 1'b0);
    chk1("mid_rst_req_ready", req_ready_o, 1'b1);
    chk1("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
    pready_dbg_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk1("post_rst_rsp_valid", rsp_valid_o, 1'b0);
      chk1("post_rst_psel", psel_dbg_o, 1'b0);
    end
    pready_dbg_i = 1'b0;
    $display("txn reset during ACCESS discarded");
    run_txn(32'h5000_0004, 32'h0, 1'b0, 4'h0, 1, 1'b0, 32'h2468_ACE0, 0);

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      run_txn($urandom, $urandom, 1'($urandom), 4'($urandom),
              int'($urandom_range(0, 5)), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msft_dbg_apb_master.md
Name: msft_dbg_apb_master

Overview:
- Debug-side APB requester that sits directly upstream of the debug APB address decoder/mux.
- Accepts single-beat read/write commands from the debug transport over a valid/ready request channel.
- Sequences each command as one APB SETUP/ACCESS transfer on the debug APB port, then returns read data and error status on a valid/ready response channel.
- One outstanding transfer at a time.

Parameters:
- APB_ADDR_WIDTH, 32, address width of request and APB ports
- APB_DATA_WIDTH, 32, data width; must be a multiple of 8
- TIMEOUT_CYCLES, 1024, ACCESS-phase cycles allowed before abort (optional feature only); minimum 1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when high with req_valid_i
- req_addr_i  in  APB_ADDR_WIDTH  byte address
- req_wdata_i  in  APB_DATA_WIDTH  write data
- req_write_i  in  1  1=write, 0=read
- req_strb_i  in  APB_DATA_WIDTH/8  write byte strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  APB_DATA_WIDTH  read data (0 for writes)
- rsp_err_o  out  1  transfer error
- rsp_timeout_o  out  1  error caused by timeout
- busy_o  out  1  high in any state other than IDLE
- psel_dbg_o, penable_dbg_o, pwrite_dbg_o  out  1  APB controls
- paddr_dbg_o  out  APB_ADDR_WIDTH  APB address
- pwdata_dbg_o  out  APB_DATA_WIDTH  APB write data
- pstrb_dbg_o  out  APB_DATA_WIDTH/8  APB strobes
- prdata_dbg_i  in  APB_DATA_WIDTH  APB read data
- pready_dbg_i  in  1  APB ready
- psuberr_dbg_i  in  1  APB error

Behaviour:
- Clocking: single clock domain, clk_i. rst_i is synchronous and active-high.
- Reset values: all outputs 0 except req_ready_o=1; state IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, register addr, wdata, write and strb; go to SETUP.
  - For reads the registered strb is 0 and pwdata_dbg_o is 0.
- SETUP: psel_dbg_o=1, penable_dbg_o=0, command registers driven onto the APB port; go to ACCESS next cycle unconditionally.
- ACCESS:
  - psel_dbg_o=1, penable_dbg_o=1.
  - Hold while pready_dbg_i=0.
  - On pready_dbg_i=1: capture rdata (reads only; writes give 0) and rsp_err_o=psuberr_dbg_i; go to RESP.
- RESP:
  - psel_dbg_o=0, penable_dbg_o=0, rsp_valid_o=1.
  - Response fields stay stable until rsp_ready_i; then go to IDLE.
  - req_ready_o=0 in this state, including the rsp_ready_i cycle. No request/response overlap.
- APB stability: paddr/pwdata/pwrite/pstrb are stable from SETUP through the last ACCESS cycle. Address/data outputs may hold their last value in IDLE.
- Latency: request accepted at edge N gives SETUP in cycle N+1 and ACCESS in N+2. With zero-wait pready, rsp_valid_o is high in cycle N+3. Each wait state adds one cycle.
- req_ready_o is low in SETUP, ACCESS and RESP.
- Request inputs are ignored whenever req_ready_o=0.
- rst_i asserted mid-transfer: next edge returns to IDLE with psel/penable dropped; any pending response is discarded.
- No arithmetic beyond the timeout counter, which saturates and never wraps.

Optional Feature:
- Macro: MSFT_DBG_APB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with pready_dbg_i=0.
  - When the count reaches TIMEOUT_CYCLES, the next edge drops psel/penable and enters RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - If pready_dbg_i=1 in the same cycle the limit is reached, pready wins: normal completion, rsp_timeout_o=0.
- Disabled: ACCESS waits indefinitely; rsp_timeout_o is tied 0; no counter logic is present.

Test Plan:
- Reset, then idle: req_ready_o=1, psel_dbg_o=0, rsp_valid_o=0, busy_o=0.
- Read 0x1000_0004, pready=1 immediately, prdata=0xA5A5_1234: SETUP at N+1, ACCESS at N+2, rsp_valid at N+3; rdata=0xA5A5_1234, err=0; pstrb=0 throughout.
- Write 0x2000_0010, wdata=0xCAFE_F00D, strb=0x3, pready low for 3 ACCESS cycles:
  - APB signals stable for all 4 ACCESS cycles; rsp at N+6 with rdata=0, err=0.
  - rsp_ready_i held low 5 cycles: response held stable and req_ready_o=0 throughout.
- Read 0x3000_0000 with pready=1 and psuberr=1 (unmapped region): rsp_err_o=1, rsp_timeout_o=0.
- Macro on, TIMEOUT_CYCLES=8, pready held 0: after 8 ACCESS cycles psel drops; rsp err=1, timeout=1, rdata=0. Same case with pready=1 in the 8th cycle gives normal completion.
- rst_i pulsed during ACCESS: psel_dbg_o=0 next cycle, state IDLE, no rsp_valid_o; a following read completes normally.
